// File: rtl/mem_responder_pkg.sv
// ============================================================================
// mem_responder_pkg
//   Bus-responder state encodings and width defaults shared with the
//   processor's bus-side logic.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_responder_pkg;

    localparam int WIDTH_DEFAULT  = 8;
    localparam int ADDR_W_DEFAULT = 8;
    localparam int WAIT_W         = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

`default_nettype wire

// File: rtl/mem_responder_byte_ram.sv
// ============================================================================
// byte_ram
//   2**ADDR_W x WIDTH storage: one synchronous write port, two asynchronous
//   read ports (bus and debug). Contents are never reset.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_ram #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder
//   Memory-side responder for the 8-bit multicycle processor bus with
//   programmable wait states, a preload port and a combinational debug port.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] adr,
    input  logic [WIDTH-1:0]  writedata,
    output logic [WIDTH-1:0]  memdata,
    output logic              ready,
    output logic              busy,
    output logic              err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WIDTH-1:0]  load_data,
    input  logic [ADDR_W-1:0] dbg_address,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam logic [WAIT_W-1:0] WAIT_INIT =
        (WAIT_STATES > 0) ? WAIT_W'(WAIT_STATES - 1) : '0;
    localparam bit NO_WAIT = (WAIT_STATES == 0);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WAIT_W-1:0] cnt;
    op_e               op_q;
    logic [ADDR_W-1:0] adr_q;
    logic [WIDTH-1:0]  wd_q;

    logic              capture;
    logic              finish;
    logic              loading;
    op_e               acc_op;
    logic [ADDR_W-1:0] acc_adr;
    logic [WIDTH-1:0]  acc_wd;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [WIDTH-1:0]  ram_wdata;
    logic [WIDTH-1:0]  bus_rdata;

    // With no wait states the access happens on the capture edge itself, so
    // the live bus values are used instead of the (not yet loaded) captures.
    always_comb begin
        loading   = (state == S_IDLE) && load_en;
        capture   = (state == S_IDLE) && !load_en && (memread ^ memwrite);
        finish    = ((state == S_WAIT) && (cnt == '0)) || (capture && NO_WAIT);
        acc_op    = (state == S_IDLE) ? (memwrite ? OP_WRITE : OP_READ) : op_q;
        acc_adr   = (state == S_IDLE) ? adr : adr_q;
        acc_wd    = (state == S_IDLE) ? writedata : wd_q;
        ram_we    = !reset && (loading || (finish && (acc_op == OP_WRITE)));
        ram_waddr = loading ? load_addr : acc_adr;
        ram_wdata = loading ? load_data : acc_wd;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (capture) state_nxt = NO_WAIT ? S_DONE : S_WAIT;
            S_WAIT:  if (cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_q    <= OP_READ;
            adr_q   <= '0;
            wd_q    <= '0;
            memdata <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= (state == S_DONE);
            err   <= (state == S_IDLE) && memread && memwrite;
            if (capture) begin
                op_q  <= memwrite ? OP_WRITE : OP_READ;
                adr_q <= adr;
                wd_q  <= writedata;
                cnt   <= WAIT_INIT;
            end else if ((state == S_WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (finish && (acc_op == OP_READ)) begin
                memdata <= bus_rdata;
            end
        end
    end

    assign busy = (state == S_WAIT) || (state == S_DONE);

    byte_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (acc_adr),
        .rdata_a (bus_rdata),
        .raddr_b (dbg_address),
        .rdata_b (dbg_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder
//   Self-checking bench: one responder with no wait states, one with one.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       memread   [2];
    logic       memwrite  [2];
    logic [7:0] adr       [2];
    logic [7:0] writedata [2];
    logic [7:0] memdata   [2];
    logic       ready     [2];
    logic       busy      [2];
    logic       err       [2];
    logic       load_en   [2];
    logic [7:0] load_addr [2];
    logic [7:0] load_data [2];
    logic [7:0] dbg_address [2];
    logic [7:0] dbg_data  [2];

    int checks   = 0;
    int failures = 0;
    logic [7:0] model [2][256];

    always #5 clk = ~clk;

    // Instance k has WAIT_STATES = k.
    mem_responder #(.WIDTH(8), .ADDR_W(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .memread(memread[0]), .memwrite(memwrite[0]),
        .adr(adr[0]), .writedata(writedata[0]), .memdata(memdata[0]), .ready(ready[0]),
        .busy(busy[0]), .err(err[0]), .load_en(load_en[0]), .load_addr(load_addr[0]),
        .load_data(load_data[0]), .dbg_address(dbg_address[0]), .dbg_data(dbg_data[0])
    );

    mem_responder #(.WIDTH(8), .ADDR_W(8), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset(reset), .memread(memread[1]), .memwrite(memwrite[1]),
        .adr(adr[1]), .writedata(writedata[1]), .memdata(memdata[1]), .ready(ready[1]),
        .busy(busy[1]), .err(err[1]), .load_en(load_en[1]), .load_addr(load_addr[1]),
        .load_data(load_data[1]), .dbg_address(dbg_address[1]), .dbg_data(dbg_data[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dbg(input int k, input logic [7:0] a);
        dbg_address[k] = a;
        #1;
        chk($sformatf("dbg[%0d]@%02h", k, a), {24'd0, dbg_data[k]}, {24'd0, model[k][a]});
    endtask

    // One bus access; the request is held for a single capture cycle, then
    // the bus lines are scrambled to show they are ignored after capture.
    task automatic access(input int k, input bit wr, input logic [7:0] a, input logic [7:0] d);
        int  n;
        bit  seen;
        memread[k]   = !wr;
        memwrite[k]  = wr;
        adr[k]       = a;
        writedata[k] = d;
        tick();
        memread[k]   = 1'b0;
        memwrite[k]  = 1'b0;
        adr[k]       = 8'($urandom);
        writedata[k] = 8'($urandom);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            seen = (ready[k] === 1'b1);
        end
        chk($sformatf("latency[%0d]", k), n, k + 1);
        if (wr) model[k][a] = d;
        else chk($sformatf("rdata[%0d]@%02h", k, a), {24'd0, memdata[k]}, {24'd0, model[k][a]});
    endtask

    initial begin
        bit          saw_ready;
        logic [7:0]  d6;
        logic [7:0]  bytes5 [4];
        bytes5 = '{8'h20, 8'h02, 8'h00, 8'h05};

        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            memread[k] = 0; memwrite[k] = 0; adr[k] = 0; writedata[k] = 0;
            load_en[k] = 0; load_addr[k] = 0; load_data[k] = 0; dbg_address[k] = 0;
        end
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_memdata[%0d]", k), {24'd0, memdata[k]}, 32'd0);
            chk($sformatf("rst_ready[%0d]", k), {31'd0, ready[k]}, 32'd0);
            chk($sformatf("rst_err[%0d]", k), {31'd0, err[k]}, 32'd0);
            chk($sformatf("rst_busy[%0d]", k), {31'd0, busy[k]}, 32'd0);
        end
        reset = 1'b0;
        tick();

        // Preload every byte of both memories.
        for (int a = 0; a < 256; a++) begin
            for (int k = 0; k < 2; k++) begin
                model[k][a] = 8'($urandom);
                if (a == 8'h10) model[k][a] = 8'h55;
                if (a == 8'h03) model[k][a] = 8'h8C;
                if (k == 0 && a < 4) model[k][a] = bytes5[a];
                load_en[k]   = 1'b1;
                load_addr[k] = 8'(a);
                load_data[k] = model[k][a];
            end
            tick();
        end
        load_en[0] = 1'b0;
        load_en[1] = 1'b0;
        tick();

        // Reset in the middle of a write's wait state.
        memwrite[1] = 1'b1; adr[1] = 8'h10; writedata[1] = 8'hAA;
        tick();
        memwrite[1] = 1'b0;
        chk("t1_busy_before_reset", {31'd0, busy[1]}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t1_busy_in_reset", {31'd0, busy[1]}, 32'd0);
        tick();
        reset = 1'b0;
        saw_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_ready |= (ready[1] === 1'b1);
        end
        chk("t1_no_ready", {31'd0, saw_ready}, 32'd0);
        chk("t1_memdata", {24'd0, memdata[1]}, 32'd0);
        chk_dbg(1, 8'h10);

        // Preloaded read, write/read-back.
        access(1, 1'b0, 8'h03, 8'h00);
        access(1, 1'b1, 8'h20, 8'h3C);
        access(1, 1'b0, 8'h20, 8'h00);
        chk_dbg(1, 8'h20);

        // Conflicting request.
        memread[1] = 1'b1; memwrite[1] = 1'b1; adr[1] = 8'h20; writedata[1] = 8'h99;
        tick();
        chk("t4_err_pulse", {31'd0, err[1]}, 32'd1);
        chk("t4_not_busy", {31'd0, busy[1]}, 32'd0);
        memread[1] = 1'b0; memwrite[1] = 1'b0;
        tick();
        chk("t4_err_clear", {31'd0, err[1]}, 32'd0);
        chk("t4_no_ready", {31'd0, ready[1]}, 32'd0);
        chk_dbg(1, 8'h20);

        // Held read with no wait states: one response every two cycles.
        memread[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            adr[0] = 8'(i);
            tick();
            chk($sformatf("t5_ready_low_%0d", i), {31'd0, ready[0]}, 32'd0);
            tick();
            chk($sformatf("t5_ready_high_%0d", i), {31'd0, ready[0]}, 32'd1);
            chk($sformatf("t5_memdata_%0d", i), {24'd0, memdata[0]}, {24'd0, bytes5[i]});
        end
        memread[0] = 1'b0;
        tick();
        chk("t5_ready_end", {31'd0, ready[0]}, 32'd0);

        // Preload collides with a read of the same byte.
        d6 = 8'($urandom) ^ model[1][8'h44];
        if (d6 == model[1][8'h44]) d6 = ~d6;
        load_en[1] = 1'b1; load_addr[1] = 8'h44; load_data[1] = d6;
        memread[1] = 1'b1; adr[1] = 8'h44;
        tick();
        model[1][8'h44] = d6;
        chk("t6_load_blocks_capture", {31'd0, busy[1]}, 32'd0);
        load_en[1] = 1'b0;
        tick();
        chk("t6_capture_next", {31'd0, busy[1]}, 32'd1);
        memread[1] = 1'b0;
        adr[1] = 8'h03;
        tick();
        tick();
        chk("t6_ready", {31'd0, ready[1]}, 32'd1);
        chk("t6_memdata", {24'd0, memdata[1]}, {24'd0, d6});

        // Random mix of reads, writes and preloads against the model.
        for (int i = 0; i < 80; i++) begin
            int          k;
            int          op;
            logic [7:0]  a;
            logic [7:0]  d;
            k  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 2));
            a  = 8'($urandom);
            d  = 8'($urandom);
            if (op == 2) begin
                load_en[k] = 1'b1; load_addr[k] = a; load_data[k] = d;
                tick();
                load_en[k] = 1'b0;
                model[k][a] = d;
                chk_dbg(k, a);
            end else begin
                access(k, op == 1, a, d);
                chk_dbg(k, (i % 3 == 0) ? a : 8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
